// File: rtl/pipe_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, valid/ready handshake,
// stall and flush, plus a saturating counter of cycles the held word was blocked.
module pipe_stage #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   input  logic              clr_cnt_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              r_state;
   logic                r_in_ready;
   logic [DATA_W-1:0]   r_main;
   logic [DATA_W-1:0]   r_skid;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_main_valid;
   logic                w_push;
   logic                w_pop;
   logic                w_blocked;

   assign w_main_valid = (r_state != ST_EMPTY);
   assign w_push       = in_valid_i & r_in_ready;
   assign w_pop        = out_valid_o & out_ready_i;
   assign w_blocked    = w_main_valid & (stall_i | ~out_ready_i);

   assign out_valid_o  = w_main_valid & ~stall_i;
   assign out_data_o   = r_main;
   assign in_ready_o   = r_in_ready;
   assign occupancy_o  = r_state;
   assign stall_cnt_o  = r_stall_cnt;

   // Occupancy FSM: ready is registered, so it is computed from the next state here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
         r_main     <= '0;
         r_skid     <= '0;
      end else if (flush_i) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               r_in_ready <= 1'b1;
               if (w_push) begin
                  r_state <= ST_ONE;
                  r_main  <= in_data_i;
               end
            end
            ST_ONE: begin
               if (w_push && !w_pop) begin
                  r_state    <= ST_FULL;
                  r_skid     <= in_data_i;
                  r_in_ready <= 1'b0;
               end else if (w_push && w_pop) begin
                  r_main     <= in_data_i;
                  r_in_ready <= 1'b1;
               end else if (w_pop) begin
                  r_state    <= ST_EMPTY;
                  r_in_ready <= 1'b1;
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            ST_FULL: begin
               // Ready is low here, so only a pop can move the skid word forward.
               if (w_pop) begin
                  r_state    <= ST_ONE;
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
               end else begin
                  r_in_ready <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_EMPTY;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   // Saturating blocked-cycle counter; clear wins over increment, flush is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (clr_cnt_i) begin
         r_stall_cnt <= '0;
      end else if (w_blocked && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed plus randomized bench for pipe_stage; a queue-based FIFO model supplies every expectation.
module tb_pipe_stage;

   localparam int DW = 16;
   localparam int CW = 2;
   localparam int CNT_SAT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i;
   logic          stall_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] in_data_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] out_data_o;
   logic [1:0]    occupancy_o;
   logic          clr_cnt_i;
   logic [CW-1:0] stall_cnt_o;

   int            checks = 0;
   int            errors = 0;

   logic [DW-1:0] exp_q[$];
   bit            m_ready;
   int            m_cnt;

   always #5 clk = ~clk;

   pipe_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .stall_i     (stall_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .occupancy_o (occupancy_o),
      .clr_cnt_i   (clr_cnt_i),
      .stall_cnt_o (stall_cnt_o)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Mid-cycle monitor: compares DUT against the FIFO model, then advances the model.
   always @(negedge clk) begin
      bit ev, pop, push, blocked;
      if (!rst) begin
         chk("rst_occupancy", occupancy_o, 0);
         chk("rst_out_valid", out_valid_o, 0);
         chk("rst_in_ready", in_ready_o, 0);
         chk("rst_out_data", out_data_o, 0);
         chk("rst_stall_cnt", stall_cnt_o, 0);
         exp_q.delete();
         m_ready = 1'b0;
         m_cnt   = 0;
      end else begin
         ev      = (exp_q.size() > 0) && !stall_i;
         blocked = (exp_q.size() > 0) && (stall_i || !out_ready_i);
         pop     = ev && out_ready_i;
         push    = in_valid_i && m_ready;
         chk("out_valid", out_valid_o, ev);
         chk("in_ready", in_ready_o, m_ready);
         chk("occupancy", occupancy_o, exp_q.size());
         chk("stall_cnt", stall_cnt_o, m_cnt);
         if (ev) chk("out_data", out_data_o, exp_q[0]);
         if (flush_i) begin
            exp_q.delete();
            m_ready = 1'b1;
         end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(in_data_i);
            m_ready = (exp_q.size() != 2);
         end
         if (clr_cnt_i) m_cnt = 0;
         else if (blocked && m_cnt < CNT_SAT) m_cnt++;
      end
   end

   task automatic step(input bit v, input logic [DW-1:0] d, input bit ordy,
                       input bit st = 1'b0, input bit fl = 1'b0, input bit cl = 1'b0);
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = ordy;
      stall_i     = st;
      flush_i     = fl;
      clr_cnt_i   = cl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
      stall_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Fill and stream
      step(1'b0, 16'h0000, 1'b1);
      step(1'b1, 16'h0011, 1'b1);
      step(1'b1, 16'h0022, 1'b1);
      step(1'b1, 16'h0033, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      // Back-pressure into skid
      step(1'b1, 16'h000A, 1'b1);
      step(1'b1, 16'h000B, 1'b0);
      step(1'b1, 16'h00EE, 1'b0);
      step(1'b0, 16'h0000, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      // Stall for three cycles
      step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      // Flush while full, with a concurrent push attempt
      step(1'b1, 16'h0005, 1'b1);
      step(1'b1, 16'h0006, 1'b0);
      step(1'b1, 16'h0007, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      // Flush in ONE with an accepted push that must be dropped
      step(1'b1, 16'h0015, 1'b0);
      step(1'b1, 16'h0016, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      // Counter saturation and clear
      step(1'b1, 16'h0009, 1'b0);
      repeat (5) step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b1);
      // Async reset while full
      step(1'b1, 16'h0001, 1'b0);
      step(1'b1, 16'h0002, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_occupancy", occupancy_o, 0);
      chk("async_out_valid", out_valid_o, 0);
      chk("async_stall_cnt", stall_cnt_o, 0);
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) < 65,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 3);
      end
      repeat (4) step(1'b0, 16'h0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
